// File: rtl/erasure_decode_sequencer.sv
// Erasure-decode sequencer: scans a 10-bit erasure mask, launches the (10,8) RS
// erasure engine and returns a status. Optional statistics under ERASURE_STAT_EN.
module erasure_decode_sequencer #(
  parameter int N_SYM       = 10,
  parameter int LOC_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_SYM-1:0] in_mask,
  output logic             eng_start,
  output logic [1:0]       eng_mode,
  output logic [LOC_W-1:0] eng_first_loc,
  output logic [LOC_W-1:0] eng_second_loc,
  input  logic             eng_done,
  input  logic             eng_uncorr,
  output logic             out_valid,
  output logic [1:0]       out_status,
  input  logic             out_ready
`ifdef ERASURE_STAT_EN
  ,
  output logic [15:0]      stat_ce_cnt,
  output logic [15:0]      stat_due_cnt
`endif
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] ST_CLEAN   = 2'b00;
  localparam logic [1:0] ST_CORR    = 2'b01;
  localparam logic [1:0] ST_DUE     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [N_SYM-1:0] mask_q, mask_d;
  logic [LOC_W-1:0] idx_q, idx_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [LOC_W-1:0] first_q, first_d;
  logic [LOC_W-1:0] second_q, second_d;
  logic [1:0]       status_q, status_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic [LOC_W-1:0] scan_loc;
  logic             scan_hit;
  logic             third_hit;
  logic             launched;

  // Mask bit 9 is location 0, so the scan walks idx downward from 9.
  assign scan_loc  = LOC_W'(N_SYM - 1) - idx_q;
  assign scan_hit  = mask_q[idx_q];
  assign third_hit = scan_hit && (cnt_q == 2'd2);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    second_d = second_q;
    status_d = status_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mask_d   = in_mask;
          cnt_d    = 2'd0;
          first_d  = '0;
          second_d = '0;
          idx_d    = LOC_W'(N_SYM - 1);
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_hit) begin
          case (cnt_q)
            2'd0: begin
              first_d = scan_loc;
              cnt_d   = 2'd1;
            end
            2'd1: begin
              second_d = scan_loc;
              cnt_d    = 2'd2;
            end
            default: begin
              cnt_d    = 2'd3;
              status_d = ST_DUE;
              state_d  = S_RESP;
            end
          endcase
        end
        if (!third_hit) begin
          if (idx_q == '0) begin
            state_d = S_ISSUE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final watchdog cycle still wins over the timeout.
        if (eng_done) begin
          if (eng_uncorr)          status_d = ST_DUE;
          else if (cnt_q == 2'd0)  status_d = ST_CLEAN;
          else                     status_d = ST_CORR;
          state_d = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      first_q  <= '0;
      second_q <= '0;
      status_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      second_q <= second_d;
      status_q <= status_d;
      wd_q     <= wd_d;
    end
  end

  // Engine fields stay valid from launch until the response leaves; an aborted
  // request never launched, so its fields stay zero.
  assign launched       = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                          ((state_q == S_RESP) && (cnt_q != 2'd3));
  assign in_ready       = (state_q == S_IDLE);
  assign eng_start      = (state_q == S_ISSUE);
  assign eng_mode       = launched ? cnt_q : 2'b00;
  assign eng_first_loc  = launched ? first_q : '0;
  assign eng_second_loc = launched ? second_q : '0;
  assign out_valid      = (state_q == S_RESP);
  assign out_status     = (state_q == S_RESP) ? status_q : 2'b00;

`ifdef ERASURE_STAT_EN
  logic [15:0] ce_q, ce_d;
  logic [15:0] due_q, due_d;
  logic        resp_hs;

  assign resp_hs = (state_q == S_RESP) && out_ready;

  always_comb begin
    ce_d  = ce_q;
    due_d = due_q;
    if (resp_hs && (status_q == ST_CORR) && (ce_q != 16'hFFFF))
      ce_d = ce_q + 16'd1;
    if (resp_hs && ((status_q == ST_DUE) || (status_q == ST_TIMEOUT)) && (due_q != 16'hFFFF))
      due_d = due_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ce_q  <= '0;
      due_q <= '0;
    end else begin
      ce_q  <= ce_d;
      due_q <= due_d;
    end
  end

  assign stat_ce_cnt  = ce_q;
  assign stat_due_cnt = due_q;
`endif

endmodule

// File: tb/tb_erasure_decode_sequencer.sv
// Self-checking bench for erasure_decode_sequencer: directed and random requests
// against a location-list reference model and a reactive engine stub.
module tb_erasure_decode_sequencer;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_mask = '0;
  logic       eng_start;
  logic [1:0] eng_mode;
  logic [3:0] eng_first_loc;
  logic [3:0] eng_second_loc;
  logic       eng_done = 1'b0;
  logic       eng_uncorr = 1'b0;
  logic       out_valid;
  logic [1:0] out_status;
  logic       out_ready = 1'b0;
`ifdef ERASURE_STAT_EN
  logic [15:0] stat_ce_cnt;
  logic [15:0] stat_due_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int exp_ce = 0;
  int exp_due = 0;

  erasure_decode_sequencer #(.N_SYM(10), .LOC_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .eng_start(eng_start), .eng_mode(eng_mode),
    .eng_first_loc(eng_first_loc), .eng_second_loc(eng_second_loc),
    .eng_done(eng_done), .eng_uncorr(eng_uncorr),
    .out_valid(out_valid), .out_status(out_status), .out_ready(out_ready)
`ifdef ERASURE_STAT_EN
    , .stat_ce_cnt(stat_ce_cnt), .stat_due_cnt(stat_due_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "simulation bound exceeded");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef ERASURE_STAT_EN
    check("stat_ce", 32'(stat_ce_cnt), 32'(exp_ce));
    check("stat_due", 32'(stat_due_cnt), 32'(exp_due));
`endif
  endtask

  // One request. d = cycles from eng_start to eng_done (1 = zero-latency engine).
  task automatic run_txn(input string name, input logic [9:0] mask, input int d,
                         input logic unc, input int hold, input bit stray);
    int locs[$];
    int n, exp_cyc, c, start_c, starts, obs_cyc;
    bit abort, seen, ready_bad;
    logic [1:0] exp_st, exp_mode, obs_mode;
    int exp_f, exp_s, obs_f, obs_s, hold_f, hold_s;

    for (int l = 0; l < 10; l++) if (mask[9 - l]) locs.push_back(l);
    n = locs.size();
    abort = (n >= 3);
    exp_f = 0; exp_s = 0; exp_mode = 2'b00;
    if (abort) begin
      exp_cyc = locs[2] + 2;
      exp_st  = 2'b10;
    end else begin
      exp_mode = 2'(n);
      if (n >= 1) exp_f = locs[0];
      if (n == 2) exp_s = locs[1];
      if (d <= TO) begin
        exp_cyc = 12 + d;
        exp_st  = unc ? 2'b10 : ((n == 0) ? 2'b00 : 2'b01);
      end else begin
        exp_cyc = 12 + TO;
        exp_st  = 2'b11;
      end
    end

    @(negedge clk);
    check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mask  = mask;
    @(posedge clk);
    c = 1; start_c = -1; starts = 0; seen = 0; ready_bad = 0; obs_cyc = -1;
    obs_mode = 2'b00; obs_f = 0; obs_s = 0; hold_f = 0; hold_s = 0;
    while (!seen && c < 200) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (eng_start) begin
        starts++;
        if (start_c < 0) begin
          start_c  = c;
          obs_mode = eng_mode;
          obs_f    = int'(eng_first_loc);
          obs_s    = int'(eng_second_loc);
        end
      end
      if (in_ready) ready_bad = 1;
      if (out_valid) begin
        seen    = 1;
        obs_cyc = c;
        hold_f  = int'(eng_first_loc);
        hold_s  = int'(eng_second_loc);
      end
      eng_done   = !seen && ((start_c >= 0 && c == start_c + d) || (stray && c == 5));
      eng_uncorr = (stray && c == 5) ? 1'b1 : unc;
      if (!seen) begin
        @(posedge clk);
        c++;
      end
    end
    eng_done = 1'b0;
    check({name, "_resp_seen"}, 32'(seen), 32'd1);
    check({name, "_resp_cycle"}, 32'(obs_cyc), 32'(exp_cyc));
    check({name, "_status"}, 32'(out_status), 32'(exp_st));
    check({name, "_start_count"}, 32'(starts), abort ? 32'd0 : 32'd1);
    check({name, "_busy_ready"}, 32'(ready_bad), 32'd0);
    if (!abort) begin
      check({name, "_start_cycle"}, 32'(start_c), 32'd11);
      check({name, "_mode"}, 32'(obs_mode), 32'(exp_mode));
      check({name, "_first_loc"}, 32'(obs_f), 32'(exp_f));
      check({name, "_second_loc"}, 32'(obs_s), 32'(exp_s));
      check({name, "_first_held"}, 32'(hold_f), 32'(exp_f));
      check({name, "_second_held"}, 32'(hold_s), 32'(exp_s));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_status"}, 32'(out_status), 32'(exp_st));
      check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_st == 2'b01 && exp_ce < 65535) exp_ce++;
    if ((exp_st == 2'b10 || exp_st == 2'b11) && exp_due < 65535) exp_due++;
    check({name, "_after_valid"}, 32'(out_valid), 32'd0);
    check({name, "_after_ready"}, 32'(in_ready), 32'd1);
    check_stats();
    $display("txn %s mask=%b d=%0d unc=%0d status=%0d cycle=%0d", name, mask, d, unc, out_status, obs_cyc);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_outs"}, {25'd0, eng_start, eng_mode, out_valid, out_status},
          32'd0);
    check({name, "_locs"}, {24'd0, eng_first_loc, eng_second_loc}, 32'd0);
  endtask

  // Reset asserted k cycles after the handshake, then a stray eng_done.
  task automatic reset_mid(input string name, input logic [9:0] mask, input int k);
    bit bad;
    @(negedge clk);
    in_valid = 1'b1;
    in_mask  = mask;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_idle_outputs({name, "_in_reset"});
    exp_ce = 0;
    exp_due = 0;
    @(negedge clk);
    rstn = 1'b1;
    eng_done = 1'b1;
    eng_uncorr = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    eng_uncorr = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid || eng_start || !in_ready) bad = 1;
    end
    check({name, "_no_response"}, 32'(bad), 32'd0);
    check_stats();
    $display("reset %s at cycle %0d", name, k);
  endtask

  initial begin
    logic [9:0] m;
    int n, d, cnt;
    #1;
    check_idle_outputs("por");
    check_stats();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    run_txn("clean",      10'b0000000000, 2,   1'b0, 0, 1'b0);
    run_txn("single4",    10'b0000100000, 3,   1'b0, 1, 1'b0);
    run_txn("double0_9",  10'b1000000001, 1,   1'b0, 0, 1'b0);
    run_txn("triple_ab",  10'b1110000000, 1,   1'b0, 0, 1'b0);
    run_txn("triple_late",10'b0000000111, 1,   1'b0, 0, 1'b0);
    run_txn("uncorr",     10'b0100000000, 1,   1'b1, 0, 1'b0);
    run_txn("done_last",  10'b0000000010, TO,  1'b0, 0, 1'b0);
    run_txn("timeout",    10'b0000010000, 500, 1'b0, 5, 1'b0);
    reset_mid("rst_scan", 10'b0010000000, 4);
    reset_mid("rst_wait", 10'b0000000001, 20);

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 4);
      m = '0;
      cnt = 0;
      while (cnt < n) begin
        int b;
        b = $urandom_range(0, 9);
        if (!m[b]) begin
          m[b] = 1'b1;
          cnt++;
        end
      end
      d = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(1, 6);
      run_txn($sformatf("rnd%0d", t), m, d, ($urandom_range(0, 3) == 0),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
